// File: rtl/retry_scheduler.sv
// retry_scheduler: holds watchdog retry requests for an exponential backoff, then
// round-robin arbitrates expired channels onto a single valid/ready reissue port.
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   retry_req      per-channel retry pulse; retry_cnt is sampled with it
//   retry_cnt      flattened per-channel retry counts, RETRY_CNT_W bits each
//   abort          per-channel cancel of a retry not yet presented downstream
//   reissue_valid  reissue command valid, held until accepted
//   reissue_ready  downstream accepts the command
//   reissue_ch     channel being reissued
//   pending_mask   channel is in BACKOFF, READY or GRANTED
//   dup_cnt        saturating count of cycles with ignored duplicate requests
module retry_scheduler #(
   parameter int NUM_CH            = 8,
   parameter int RETRY_CNT_W       = 2,
   parameter int BACKOFF_BASE      = 16,
   parameter int BACKOFF_SHIFT_MAX = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             retry_req,
   input  logic [NUM_CH*RETRY_CNT_W-1:0] retry_cnt,
   input  logic [NUM_CH-1:0]             abort,
   output logic                          reissue_valid,
   input  logic                          reissue_ready,
   output logic [$clog2(NUM_CH)-1:0]     reissue_ch,
   output logic [NUM_CH-1:0]             pending_mask,
   output logic [7:0]                    dup_cnt
);
   localparam int CHW  = $clog2(NUM_CH);
   localparam int CNTW = $clog2((BACKOFF_BASE << BACKOFF_SHIFT_MAX) + 1);
   typedef enum logic [1:0] {IDLE, BACKOFF, READY, GRANTED} state_t;
   state_t            state_q [NUM_CH];
   state_t            state_n [NUM_CH];
   logic [CNTW-1:0]   cnt_q [NUM_CH];
   logic [CNTW-1:0]   cnt_n [NUM_CH];
   logic              valid_n, accept, any_dup, found;
   logic [CHW-1:0]    ch_n, ptr_q, ptr_n, win;
   logic [7:0]        dup_n;
   logic [NUM_CH-1:0] pending_n;
   int                j;
   // The counter is loaded with D-1 so the channel reads READY exactly D cycles
   // after the request cycle; D==1 skips BACKOFF entirely.
   function automatic logic [CNTW-1:0] backoff_m1(input logic [RETRY_CNT_W-1:0] c);
      int s;
      s = (int'(c) > BACKOFF_SHIFT_MAX) ? BACKOFF_SHIFT_MAX : int'(c);
      return CNTW'((BACKOFF_BASE << s) - 1);
   endfunction
   always_comb begin
      accept  = reissue_valid && reissue_ready;
      found   = 1'b0;
      win     = '0;
      j       = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NUM_CH) j = j - NUM_CH;
         if (!found && state_q[CHW'(j)] == READY) begin
            found = 1'b1;
            win   = CHW'(j);
         end
      end
      valid_n = reissue_valid;
      ch_n    = reissue_ch;
      ptr_n   = ptr_q;
      any_dup = 1'b0;
      if (accept) begin
         valid_n = 1'b0;
         ptr_n   = (reissue_ch == CHW'(NUM_CH - 1)) ? '0 : reissue_ch + 1'b1;
      end else if (!reissue_valid && found) begin
         valid_n = 1'b1;
         ch_n    = win;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         state_n[i] = state_q[i];
         cnt_n[i]   = cnt_q[i];
         case (state_q[i])
            IDLE:
               if (retry_req[i] && !abort[i]) begin
                  cnt_n[i]   = backoff_m1(retry_cnt[i*RETRY_CNT_W +: RETRY_CNT_W]);
                  state_n[i] = (cnt_n[i] == '0) ? READY : BACKOFF;
               end
            BACKOFF:
               if (abort[i]) begin
                  state_n[i] = IDLE;
                  cnt_n[i]   = '0;
               end else if (cnt_q[i] <= CNTW'(1)) begin
                  state_n[i] = READY;
                  cnt_n[i]   = '0;
               end else begin
                  cnt_n[i] = cnt_q[i] - 1'b1;
               end
            READY:
               if (abort[i]) state_n[i] = IDLE;
               else if (!reissue_valid && found && win == CHW'(i)) state_n[i] = GRANTED;
            GRANTED:
               // A retry arriving on the accepting edge starts a fresh backoff.
               if (accept) begin
                  if (retry_req[i]) begin
                     cnt_n[i]   = backoff_m1(retry_cnt[i*RETRY_CNT_W +: RETRY_CNT_W]);
                     state_n[i] = (cnt_n[i] == '0) ? READY : BACKOFF;
                  end else begin
                     state_n[i] = IDLE;
                  end
               end
         endcase
         if (retry_req[i] && !abort[i] && state_q[i] != IDLE && !(state_q[i] == GRANTED && accept))
            any_dup = 1'b1;
         pending_n[i] = (state_n[i] != IDLE);
      end
      dup_n = (any_dup && dup_cnt != 8'hFF) ? dup_cnt + 1'b1 : dup_cnt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         reissue_valid <= 1'b0;
         reissue_ch    <= '0;
         ptr_q         <= '0;
         dup_cnt       <= '0;
         pending_mask  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_n[i];
            cnt_q[i]   <= cnt_n[i];
         end
         reissue_valid <= valid_n;
         reissue_ch    <= ch_n;
         ptr_q         <= ptr_n;
         dup_cnt       <= dup_n;
         pending_mask  <= pending_n;
      end
   end
endmodule
